mem_coalescing_arbiter: RTL and testbench

Single-channel memory arbiter that shares one external memory port among NUM_CONSUMERS LSUs or fetchers, using round-robin priority. When it grants a read, it merges every other consumer currently requesting a read of the same address into one memory transaction and broadcasts the returned data to all of them. A per-transaction timeout makes sure a stalled memory cannot hang the cores. It sits between a core's LSUs and the data memory port, in place of a multi-channel controller when only one channel exists.

---
 rtl/mem_coalescing_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_mem_coalescing_arbiter.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_coalescing_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_coalescing_arbiter
//
// Shares one external memory port among NUM_CONSUMERS requesters using
// round-robin priority. A granted read is merged with every other consumer
// that is requesting a read of the same address at the grant cycle, and the
// returned data is broadcast to all of them. Writes are never merged. A
// per-transaction timeout aborts a stalled memory access and raises a sticky
// error flag.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   consumer_read_valid/_address   per-consumer read request (flattened)
//   consumer_read_ready/_data      per-consumer read response (flattened)
//   consumer_write_valid/_address/_data  per-consumer write request
//   consumer_write_ready       per-consumer write completion
//   mem_read_valid/_address    memory read request
//   mem_read_ready/_data       memory read response
//   mem_write_valid/_address/_data  memory write request
//   mem_write_ready            memory write acknowledge
//   timeout_error              sticky, set on any memory timeout
//   busy                       high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module mem_coalescing_arbiter #(
   parameter int ADDR_BITS      = 8,
   parameter int DATA_BITS      = 16,
   parameter int NUM_CONSUMERS  = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
   input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
   output logic                               mem_read_valid,
   output logic [ADDR_BITS-1:0]               mem_read_address,
   input  logic                               mem_read_ready,
   input  logic [DATA_BITS-1:0]               mem_read_data,
   output logic                               mem_write_valid,
   output logic [ADDR_BITS-1:0]               mem_write_address,
   output logic [DATA_BITS-1:0]               mem_write_data,
   input  logic                               mem_write_ready,
   output logic                               timeout_error,
   output logic                               busy
);

   localparam int PTR_W = $clog2(NUM_CONSUMERS);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ_WAITING,
      S_WRITE_WAITING,
      S_RELAYING
   } state_e;

   state_e                           state_q;
   logic [PTR_W-1:0]                 rr_ptr_q;
   logic [NUM_CONSUMERS-1:0]         serve_mask_q;
   logic [CNT_W-1:0]                 count_q;
   logic                             is_write_q;
   logic [NUM_CONSUMERS-1:0]         rd_ready_q;
   logic [NUM_CONSUMERS*DATA_BITS-1:0] rd_data_q;
   logic [NUM_CONSUMERS-1:0]         wr_ready_q;
   logic                             mrv_q;
   logic [ADDR_BITS-1:0]             mra_q;
   logic                             mwv_q;
   logic [ADDR_BITS-1:0]             mwa_q;
   logic [DATA_BITS-1:0]             mwd_q;
   logic                             err_q;

   logic [NUM_CONSUMERS-1:0] any_valid;
   logic                     grant_valid;
   logic [PTR_W-1:0]         grant_idx;
   logic                     grant_is_read;
   logic [ADDR_BITS-1:0]     grant_raddr;
   logic [ADDR_BITS-1:0]     grant_waddr;
   logic [DATA_BITS-1:0]     grant_wdata;
   logic [NUM_CONSUMERS-1:0] match_mask;
   logic [NUM_CONSUMERS-1:0] grant_onehot;
   logic [PTR_W-1:0]         rr_ptr_d;
   logic [NUM_CONSUMERS-1:0] relay_keep;
   logic                     wait_ready;

   assign any_valid = consumer_read_valid | consumer_write_valid;

   // Round-robin scan: first pass covers rr_ptr_q..N-1, second pass wraps
   // around to 0..rr_ptr_q-1.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NUM_CONSUMERS; k++) begin
         if (!grant_valid && (k >= int'(rr_ptr_q)) && any_valid[k]) begin
            grant_valid = 1'b1;
            grant_idx   = PTR_W'(k);
         end
      end
      for (int k = 0; k < NUM_CONSUMERS; k++) begin
         if (!grant_valid && (k < int'(rr_ptr_q)) && any_valid[k]) begin
            grant_valid = 1'b1;
            grant_idx   = PTR_W'(k);
         end
      end
   end

   // Winner's request fields, and the set of readers sharing its address.
   always_comb begin
      grant_is_read = 1'b0;
      grant_raddr   = '0;
      grant_waddr   = '0;
      grant_wdata   = '0;
      match_mask    = '0;
      for (int k = 0; k < NUM_CONSUMERS; k++) begin
         if (PTR_W'(k) == grant_idx) begin
            grant_is_read = consumer_read_valid[k];
            grant_raddr   = consumer_read_address[k*ADDR_BITS +: ADDR_BITS];
            grant_waddr   = consumer_write_address[k*ADDR_BITS +: ADDR_BITS];
            grant_wdata   = consumer_write_data[k*DATA_BITS +: DATA_BITS];
         end
      end
      for (int k = 0; k < NUM_CONSUMERS; k++) begin
         match_mask[k] = consumer_read_valid[k] &&
                         (consumer_read_address[k*ADDR_BITS +: ADDR_BITS] == grant_raddr);
      end
   end

   assign grant_onehot = NUM_CONSUMERS'(1) << grant_idx;
   assign rr_ptr_d     = (grant_idx == PTR_W'(NUM_CONSUMERS - 1)) ? '0 : grant_idx + PTR_W'(1);
   // Served consumers still holding their request keep their ready asserted.
   assign relay_keep   = serve_mask_q & (is_write_q ? consumer_write_valid : consumer_read_valid);
   assign wait_ready   = (state_q == S_WRITE_WAITING) ? mem_write_ready : mem_read_ready;

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (reset) begin
         // NOTE: response data and memory address/data registers are reset too,
         // so every output is a known zero after reset, not only the handshakes.
         state_q      <= S_IDLE;
         rr_ptr_q     <= '0;
         serve_mask_q <= '0;
         count_q      <= '0;
         is_write_q   <= 1'b0;
         rd_ready_q   <= '0;
         rd_data_q    <= '0;
         wr_ready_q   <= '0;
         mrv_q        <= 1'b0;
         mra_q        <= '0;
         mwv_q        <= 1'b0;
         mwa_q        <= '0;
         mwd_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (grant_valid) begin
                  rr_ptr_q <= rr_ptr_d;
                  count_q  <= '0;
                  if (grant_is_read) begin
                     serve_mask_q <= match_mask;
                     is_write_q   <= 1'b0;
                     mrv_q        <= 1'b1;
                     mra_q        <= grant_raddr;
                     state_q      <= S_READ_WAITING;
                  end else begin
                     serve_mask_q <= grant_onehot;
                     is_write_q   <= 1'b1;
                     mwv_q        <= 1'b1;
                     mwa_q        <= grant_waddr;
                     mwd_q        <= grant_wdata;
                     state_q      <= S_WRITE_WAITING;
                  end
               end
            end

            S_READ_WAITING, S_WRITE_WAITING: begin
               // A ready arriving on the last allowed cycle still wins.
               if (wait_ready || (count_q == CNT_W'(TIMEOUT_CYCLES))) begin
                  mrv_q   <= 1'b0;
                  mwv_q   <= 1'b0;
                  state_q <= S_RELAYING;
                  if (!wait_ready) begin
                     err_q <= 1'b1;
                  end
                  if (state_q == S_WRITE_WAITING) begin
                     wr_ready_q <= serve_mask_q;
                  end else begin
                     rd_ready_q <= serve_mask_q;
                     for (int k = 0; k < NUM_CONSUMERS; k++) begin
                        if (serve_mask_q[k]) begin
                           rd_data_q[k*DATA_BITS +: DATA_BITS] <= wait_ready ? mem_read_data : '0;
                        end
                     end
                  end
               end else begin
                  count_q <= count_q + CNT_W'(1);
               end
            end

            S_RELAYING: begin
               serve_mask_q <= relay_keep;
               if (is_write_q) begin
                  wr_ready_q <= relay_keep;
               end else begin
                  rd_ready_q <= relay_keep;
               end
               if (relay_keep == '0) begin
                  state_q <= S_IDLE;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign consumer_read_ready  = rd_ready_q;
   assign consumer_read_data   = rd_data_q;
   assign consumer_write_ready = wr_ready_q;
   assign mem_read_valid       = mrv_q;
   assign mem_read_address     = mra_q;
   assign mem_write_valid      = mwv_q;
   assign mem_write_address    = mwa_q;
   assign mem_write_data       = mwd_q;
   assign timeout_error        = err_q;
   assign busy                 = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_coalescing_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_coalescing_arbiter
//
// Directed testbench: a consumer/memory stimulus driver, a transaction-level
// reference model compared against the DUT on every cycle, and literal
// expectations for each scenario (grant order, latencies, data values).
// -----------------------------------------------------------------------------
module tb_mem_coalescing_arbiter;

   localparam int N  = 4;
   localparam int AB = 8;
   localparam int DB = 16;
   localparam int TO = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // Consumer-side stimulus
   logic [N-1:0]  c_rv = '0;
   logic [N-1:0]  c_wv = '0;
   logic [AB-1:0] c_ra [N];
   logic [AB-1:0] c_wa [N];
   logic [DB-1:0] c_wd [N];
   logic [N*AB-1:0] ra_flat, wa_flat;
   logic [N*DB-1:0] wd_flat;

   always_comb begin
      ra_flat = '0;
      wa_flat = '0;
      wd_flat = '0;
      for (int k = 0; k < N; k++) begin
         ra_flat[k*AB +: AB] = c_ra[k];
         wa_flat[k*AB +: AB] = c_wa[k];
         wd_flat[k*DB +: DB] = c_wd[k];
      end
   end

   // DUT outputs / memory-side signals
   logic [N-1:0]    rd_ready, wr_ready;
   logic [N*DB-1:0] rd_data;
   logic            mrv, mwv, err, busy;
   logic [AB-1:0]   mra, mwa;
   logic [DB-1:0]   mwd;
   logic            mrr = 1'b0;
   logic            mwr = 1'b0;
   logic [DB-1:0]   mrd = '0;

   mem_coalescing_arbiter #(
      .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(N), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk                    (clk),
      .reset                  (reset),
      .consumer_read_valid    (c_rv),
      .consumer_read_address  (ra_flat),
      .consumer_read_ready    (rd_ready),
      .consumer_read_data     (rd_data),
      .consumer_write_valid   (c_wv),
      .consumer_write_address (wa_flat),
      .consumer_write_data    (wd_flat),
      .consumer_write_ready   (wr_ready),
      .mem_read_valid         (mrv),
      .mem_read_address       (mra),
      .mem_read_ready         (mrr),
      .mem_read_data          (mrd),
      .mem_write_valid        (mwv),
      .mem_write_address      (mwa),
      .mem_write_data         (mwd),
      .mem_write_ready        (mwr),
      .timeout_error          (err),
      .busy                   (busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: transaction-level view, advanced once per clock edge.
   // phase 0 = idle, 1 = waiting on memory, 2 = handing results back.
   // ---------------------------------------------------------------------------
   int            m_phase, m_ptr, m_wait, m_w, m_k;
   bit            m_write, m_err, m_rdy, m_any;
   bit            m_served [N];
   logic          m_rd_ready [N];
   logic          m_wr_ready [N];
   logic [DB-1:0] m_rd_data [N];
   logic          m_mrv, m_mwv;
   logic [AB-1:0] m_mra, m_mwa;
   logic [DB-1:0] m_mwd;
   int            grant_log [$];

   always @(posedge clk) begin : ref_model
      if (reset) begin
         m_phase = 0; m_ptr = 0; m_wait = 0; m_write = 0; m_err = 0;
         m_mrv = 0; m_mwv = 0; m_mra = '0; m_mwa = '0; m_mwd = '0;
         for (int k = 0; k < N; k++) begin
            m_served[k] = 0; m_rd_ready[k] = 0; m_wr_ready[k] = 0; m_rd_data[k] = '0;
         end
      end else begin
         case (m_phase)
            0: begin
               m_w = -1;
               for (int i = 0; i < N; i++) begin
                  m_k = (m_ptr + i) % N;
                  if (m_w < 0 && (c_rv[m_k] || c_wv[m_k])) m_w = m_k;
               end
               if (m_w >= 0) begin
                  grant_log.push_back(m_w);
                  m_ptr   = (m_w + 1) % N;
                  m_wait  = 0;
                  m_phase = 1;
                  m_write = c_wv[m_w];
                  if (!m_write) begin
                     m_mrv = 1; m_mra = c_ra[m_w];
                     for (int k = 0; k < N; k++) m_served[k] = c_rv[k] && (c_ra[k] == c_ra[m_w]);
                  end else begin
                     m_mwv = 1; m_mwa = c_wa[m_w]; m_mwd = c_wd[m_w];
                     for (int k = 0; k < N; k++) m_served[k] = (k == m_w);
                  end
               end
            end
            1: begin
               m_wait++;
               m_rdy = m_write ? mwr : mrr;
               if (m_rdy || m_wait == TO + 1) begin
                  if (!m_rdy) m_err = 1;
                  m_mrv = 0; m_mwv = 0; m_phase = 2;
                  for (int k = 0; k < N; k++) begin
                     if (m_served[k]) begin
                        if (m_write) m_wr_ready[k] = 1;
                        else begin
                           m_rd_ready[k] = 1;
                           m_rd_data[k]  = m_rdy ? mrd : '0;
                        end
                     end
                  end
               end
            end
            default: begin
               m_any = 0;
               for (int k = 0; k < N; k++) begin
                  if (m_served[k] && !(m_write ? c_wv[k] : c_rv[k])) begin
                     m_served[k] = 0; m_rd_ready[k] = 0; m_wr_ready[k] = 0;
                  end
                  if (m_served[k]) m_any = 1;
               end
               if (!m_any) m_phase = 0;
            end
         endcase
      end
   end

   // Per-cycle comparison, away from the active edge.
   bit chk_en = 0;
   always @(negedge clk) begin
      if (chk_en) begin
         check("timeout_error", err, m_err);
         check("busy", busy, m_phase != 0);
         check("mem_read_valid", mrv, m_mrv);
         check("mem_read_address", mra, m_mra);
         check("mem_write_valid", mwv, m_mwv);
         check("mem_write_address", mwa, m_mwa);
         check("mem_write_data", mwd, m_mwd);
         for (int k = 0; k < N; k++) begin
            check($sformatf("read_ready[%0d]", k), rd_ready[k], m_rd_ready[k]);
            check($sformatf("write_ready[%0d]", k), wr_ready[k], m_wr_ready[k]);
            check($sformatf("read_data[%0d]", k), rd_data[k*DB +: DB], m_rd_data[k]);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus driver state
   // ---------------------------------------------------------------------------
   logic [DB-1:0] mem_img [256];
   int            mem_lat = 1;   // -1: memory never answers
   int            mem_cnt = 0;
   int            cyc = 0;
   int            hold [N], auto_n [N], got_cnt [N], wgot_cnt [N];
   int            drop_cyc [N], fall_cyc [N], wr_ready_cyc [N];
   logic [DB-1:0] got_data [N];
   bit            prev_rd_ready [N];
   bit            prev_busy = 0, prev_mrv = 0, prev_mwv = 0;
   int            busy_fall_cyc, mw_rise_cyc, mrv_hi, mwv_hi;
   logic [AB-1:0] mra_log [$];
   logic [AB-1:0] mwa_log [$];
   logic [DB-1:0] mwd_log [$];

   task automatic tick();
      @(negedge clk);
      cyc++;
      for (int k = 0; k < N; k++) begin
         if (c_rv[k] && rd_ready[k]) begin
            if (hold[k] > 0) hold[k]--;
            else begin
               c_rv[k] = 1'b0;
               got_data[k] = rd_data[k*DB +: DB];
               got_cnt[k]++;
               drop_cyc[k] = cyc;
            end
         end else if (!c_rv[k] && !c_wv[k] && !rd_ready[k] && auto_n[k] > 0) begin
            auto_n[k]--;
            c_rv[k] = 1'b1;
         end
         if (c_wv[k] && wr_ready[k]) begin
            c_wv[k] = 1'b0;
            wgot_cnt[k]++;
            wr_ready_cyc[k] = cyc;
         end
         if (prev_rd_ready[k] && !rd_ready[k]) fall_cyc[k] = cyc;
         prev_rd_ready[k] = rd_ready[k];
      end
      if (prev_busy && !busy) busy_fall_cyc = cyc;
      prev_busy = busy;
      if (mrv && !prev_mrv) mra_log.push_back(mra);
      if (mwv && !prev_mwv) begin
         mwa_log.push_back(mwa);
         mwd_log.push_back(mwd);
         mw_rise_cyc = cyc;
      end
      prev_mrv = mrv;
      prev_mwv = mwv;
      if (mrv) mrv_hi++;
      if (mwv) mwv_hi++;
      if (mrv || mwv) mem_cnt++;
      else mem_cnt = 0;
      mrr = mrv && (mem_lat >= 0) && (mem_cnt == mem_lat + 1);
      mwr = mwv && (mem_lat >= 0) && (mem_cnt == mem_lat + 1);
      mrd = mem_img[mra];
   endtask

   function automatic bit pending();
      int s = 0;
      for (int k = 0; k < N; k++) s += auto_n[k];
      return (c_rv != '0) || (c_wv != '0) || busy || (s > 0);
   endfunction

   task automatic run_until_idle(input string name);
      int n = 0;
      do begin
         tick();
         n++;
      end while (pending() && n < 300);
      check({name, "_completes"}, n < 300, 1);
   endtask

   task automatic clear_logs();
      mra_log.delete(); mwa_log.delete(); mwd_log.delete(); grant_log.delete();
      mrv_hi = 0; mwv_hi = 0;
      for (int k = 0; k < N; k++) begin
         got_cnt[k] = 0; wgot_cnt[k] = 0; got_data[k] = 16'hDEAD;
      end
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      c_rv  = '0;
      c_wv  = '0;
      for (int k = 0; k < N; k++) begin
         auto_n[k] = 0; hold[k] = 0;
      end
      repeat (cycles) tick();
      chk_en = 1;
      reset  = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      int exp_order [8];
      int n;
      exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
      for (int i = 0; i < 256; i++) mem_img[i] = 16'(16'hC000 + i * 7);
      mem_img[8'h10] = 16'hBEEF;
      for (int k = 0; k < N; k++) begin
         c_ra[k] = '0; c_wa[k] = '0; c_wd[k] = '0;
         hold[k] = 0; auto_n[k] = 0; prev_rd_ready[k] = 0;
      end
      clear_logs();

      // Reset state
      do_reset(2);
      check("rst_busy", busy, 0);
      check("rst_mem_read_valid", mrv, 0);
      check("rst_timeout_error", err, 0);
      check("rst_model_ptr", m_ptr, 0);

      // Single read, memory answers on the 4th valid cycle
      clear_logs();
      mem_lat = 3;
      c_ra[2] = 8'h10; c_rv[2] = 1'b1;
      run_until_idle("single");
      check("single_mrv_cycles", mrv_hi, 4);
      check("single_ntx", mra_log.size(), 1);
      if (mra_log.size() > 0) check("single_addr", mra_log[0], 8'h10);
      check("single_data", got_data[2], 16'hBEEF);
      check("single_served", got_cnt[2], 1);
      check("single_model_ptr", m_ptr, 3);

      // rr_ptr now 3: consumer 3 must beat consumer 0
      clear_logs();
      mem_lat = 1;
      c_ra[0] = 8'h11; c_rv[0] = 1'b1;
      c_ra[3] = 8'h13; c_rv[3] = 1'b1;
      run_until_idle("rr3");
      check("rr3_ntx", mra_log.size(), 2);
      if (mra_log.size() > 1) begin
         check("rr3_first", mra_log[0], 8'h13);
         check("rr3_second", mra_log[1], 8'h11);
      end

      // Round-robin fairness with continuous requesters
      do_reset(2);
      clear_logs();
      mem_lat = 1;
      for (int k = 0; k < N; k++) begin
         c_ra[k] = 8'(8'h40 + k); c_rv[k] = 1'b1; auto_n[k] = 1;
      end
      run_until_idle("fair");
      check("fair_ntx", mra_log.size(), 8);
      check("fair_model_grants", grant_log.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < mra_log.size()) check($sformatf("fair_addr[%0d]", i), mra_log[i], 8'(8'h40 + exp_order[i]));
         if (i < grant_log.size()) check($sformatf("fair_model_grant[%0d]", i), grant_log[i], exp_order[i]);
      end
      for (int k = 0; k < N; k++) check($sformatf("fair_count[%0d]", k), got_cnt[k], 2);

      // Coalescing: 0,1,3 share 0x20, 2 reads 0x21
      do_reset(2);
      clear_logs();
      mem_lat = 2;
      c_ra[0] = 8'h20; c_ra[1] = 8'h20; c_ra[2] = 8'h21; c_ra[3] = 8'h20;
      c_rv = 4'b1111;
      run_until_idle("coal");
      check("coal_ntx", mra_log.size(), 2);
      if (mra_log.size() > 1) begin
         check("coal_addr0", mra_log[0], 8'h20);
         check("coal_addr1", mra_log[1], 8'h21);
      end
      check("coal_data0", got_data[0], 16'hC0E0);
      check("coal_data1", got_data[1], 16'hC0E0);
      check("coal_data3", got_data[3], 16'hC0E0);
      check("coal_data2", got_data[2], 16'hC0E7);
      for (int k = 0; k < N; k++) check($sformatf("coal_count[%0d]", k), got_cnt[k], 1);

      // Staggered release of a coalesced {0,3} read
      do_reset(2);
      clear_logs();
      mem_lat = 1;
      c_ra[0] = 8'h30; c_ra[3] = 8'h30;
      c_rv[0] = 1'b1;  c_rv[3] = 1'b1;
      hold[3] = 2;
      run_until_idle("stag");
      check("stag_ntx", mra_log.size(), 1);
      check("stag_drop_gap", drop_cyc[3] - drop_cyc[0], 2);
      check("stag_fall_gap", fall_cyc[3] - fall_cyc[0], 2);
      check("stag_fall0", fall_cyc[0] - drop_cyc[0], 1);
      check("stag_idle", busy_fall_cyc - drop_cyc[3], 1);

      // Write acked normally, then a write that times out
      do_reset(2);
      clear_logs();
      mem_lat = 2;
      c_wa[1] = 8'h05; c_wd[1] = 16'h1234; c_wv[1] = 1'b1;
      run_until_idle("wr");
      check("wr_ntx", mwa_log.size(), 1);
      if (mwa_log.size() > 0) begin
         check("wr_addr", mwa_log[0], 8'h05);
         check("wr_data", mwd_log[0], 16'h1234);
      end
      check("wr_acked", wgot_cnt[1], 1);
      check("wr_no_error", err, 0);
      clear_logs();
      mem_lat = -1;
      c_wa[1] = 8'h06; c_wd[1] = 16'h00AB; c_wv[1] = 1'b1;
      run_until_idle("wto");
      check("wto_ready_latency", wr_ready_cyc[1] - mw_rise_cyc, 5);
      check("wto_mwv_cycles", mwv_hi, 5);
      check("wto_error", err, 1);
      clear_logs();
      mem_lat = 1;
      c_ra[0] = 8'h10; c_rv[0] = 1'b1;
      run_until_idle("sticky");
      check("sticky_data", got_data[0], 16'hBEEF);
      repeat (3) tick();
      check("sticky_error", err, 1);
      do_reset(1);
      check("sticky_cleared", err, 0);

      // Ready on the very last allowed cycle wins over timeout
      clear_logs();
      mem_lat = 4;
      c_ra[2] = 8'h50; c_rv[2] = 1'b1;
      run_until_idle("edge");
      check("edge_mrv_cycles", mrv_hi, 5);
      check("edge_no_error", err, 0);
      check("edge_data", got_data[2], 16'hC230);

      // Read timeout returns zero data
      clear_logs();
      mem_lat = -1;
      c_ra[0] = 8'h10; c_rv[0] = 1'b1;
      run_until_idle("rto");
      check("rto_mrv_cycles", mrv_hi, 5);
      check("rto_data", got_data[0], 16'h0000);
      check("rto_error", err, 1);

      // Reset in the middle of a read
      do_reset(2);
      clear_logs();
      mem_lat = -1;
      c_ra[1] = 8'h70; c_rv[1] = 1'b1;
      n = 0;
      while (!mrv && n < 20) begin
         tick();
         n++;
      end
      check("midrst_started", mrv, 1);
      tick();
      reset = 1'b1;
      c_rv  = '0;
      tick();
      check("midrst_mrv", mrv, 0);
      check("midrst_busy", busy, 0);
      check("midrst_read_ready", rd_ready, 0);
      check("midrst_mra", mra, 0);
      reset = 1'b0;
      clear_logs();
      mem_lat = 1;
      c_ra[0] = 8'h60; c_rv[0] = 1'b1;
      c_ra[2] = 8'h62; c_rv[2] = 1'b1;
      run_until_idle("midrst");
      check("midrst_ntx", mra_log.size(), 2);
      if (mra_log.size() > 1) begin
         check("midrst_first", mra_log[0], 8'h60);
         check("midrst_second", mra_log[1], 8'h62);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
